// File: rtl/spi_sequencer_if.sv
// Bus-side and SPI pin bundle for spi_sequencer.
// The master modport is the wrapper/driver side; the slave modport is the sequencer.
interface spi_sequencer_if;
    logic [12:0] buf_addr;
    logic [7:0]  buf_wr_val;
    logic        buf_wr_en;
    logic [7:0]  buf_rd_val;
    logic [8:0]  divider;
    logic        xfer_start;
    logic [12:0] xfer_length;
    logic        xfer_complete;
    logic        miso;
    logic        mosi;
    logic        sclk;

    modport master (
        output buf_addr, buf_wr_val, buf_wr_en, divider, xfer_start, xfer_length, miso,
        input  buf_rd_val, xfer_complete, mosi, sclk
    );

    modport slave (
        input  buf_addr, buf_wr_val, buf_wr_en, divider, xfer_start, xfer_length, miso,
        output buf_rd_val, xfer_complete, mosi, sclk
    );
endinterface

// File: rtl/spi_sequencer.sv
// Byte-buffered full-duplex SPI master (mode 0, MSB first) with an internal
// dual-port transfer buffer; received bytes overwrite the bytes just sent.
module spi_sequencer #(
    parameter int BUF_BYTES = 8192
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  mem [BUF_BYTES];
    logic [8:0]  div_q;
    logic [12:0] len_q;
    logic [12:0] idx;
    logic [8:0]  half_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic        sclk_q;
    logic        mosi_q;
    logic [7:0]  rd_q;
    logic        complete;
    logic        eng_we;
    logic        half_done;
    logic        more_bytes;

    assign half_done  = (half_cnt == div_q);
    assign more_bytes = (({1'b0, idx} + 14'd1) < {1'b0, len_q});

    assign bus.sclk          = sclk_q;
    assign bus.mosi          = mosi_q;
    assign bus.buf_rd_val    = rd_q;
    assign bus.xfer_complete = complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        eng_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.xfer_start) state_next = (bus.xfer_length != 13'd0) ? LOAD : DONE;
            end
            LOAD:  state_next = SHIFT;
            SHIFT: begin
                if (half_done && sclk_q && (bit_cnt == 3'd7)) state_next = STORE;
            end
            STORE: begin
                eng_we     = 1'b1;
                state_next = more_bytes ? LOAD : DONE;
            end
            DONE: begin
                complete   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Engine writeback takes priority over a bus write to the same byte.
    always_ff @(posedge clk) begin
        if (eng_we) mem[idx] <= rx_shift;
        if (bus.buf_wr_en && !(eng_we && (bus.buf_addr == idx))) mem[bus.buf_addr] <= bus.buf_wr_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= 8'h00;
        else        rd_q <= mem[bus.buf_addr];
    end

    // Each SCLK half-period lasts div_q+1 clocks; miso is captured as sclk rises
    // and mosi advances as sclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= 9'd0;
            len_q    <= 13'd0;
            idx      <= 13'd0;
            half_cnt <= 9'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.xfer_start) begin
                        div_q <= bus.divider;
                        len_q <= bus.xfer_length;
                        idx   <= 13'd0;
                    end
                end
                LOAD: begin
                    tx_shift <= mem[idx];
                    mosi_q   <= mem[idx][7];
                    half_cnt <= 9'd0;
                    bit_cnt  <= 3'd0;
                    sclk_q   <= 1'b0;
                end
                SHIFT: begin
                    if (half_done) begin
                        half_cnt <= 9'd0;
                        if (!sclk_q) begin
                            sclk_q   <= 1'b1;
                            rx_shift <= {rx_shift[6:0], bus.miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                mosi_q   <= tx_shift[6];
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 9'd1;
                    end
                end
                STORE: begin
                    if (more_bytes) idx <= idx + 13'd1;
                    else            mosi_q <= 1'b0;
                end
                DONE: mosi_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sequencer.sv
// Scoreboard bench for spi_sequencer: expected buffer/mosi bytes are queued
// when stimulus is set up and popped as the DUT produces them.
module tb_spi_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_sequencer_if bus_if();

    spi_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mosi_exp_q[$];
    logic       mosi_bits[$];
    int         high_runs[$];
    int         low_runs[$];
    int         rises;
    int         completes;
    int         unstable;
    int         first_complete_cyc;
    bit         timed_out;
    int         miso_mode;
    logic [7:0] miso_pat;

    function automatic logic [7:0] mosi_byte(input int n);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            if (8*n + i < mosi_bits.size()) b[7-i] = mosi_bits[8*n + i];
        return b;
    endfunction

    task automatic bus_write(input logic [12:0] a, input logic [7:0] v);
        @(negedge clk);
        bus_if.buf_addr   = a;
        bus_if.buf_wr_val = v;
        bus_if.buf_wr_en  = 1'b1;
        @(negedge clk);
        bus_if.buf_wr_en  = 1'b0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [7:0] v);
        @(negedge clk);
        bus_if.buf_addr = a;
        @(negedge clk);
        v = bus_if.buf_rd_val;
    endtask

    // Starts a transfer and watches sclk/mosi/xfer_complete at every falling clk
    // edge; optionally pulses a second start or asserts reset at a given cycle.
    task automatic run_xfer(input logic [12:0] len, input logic [8:0] div,
                            input int extra_at, input int abort_at);
        int   cyc = 0;
        int   tail = 0;
        int   run_h = 0;
        int   run_l = 0;
        logic s, m, prev_s, prev_m;
        mosi_bits.delete();
        high_runs.delete();
        low_runs.delete();
        rises = 0;
        completes = 0;
        unstable = 0;
        first_complete_cyc = 0;
        timed_out = 1'b1;
        @(negedge clk);
        bus_if.xfer_length = len;
        bus_if.divider     = div;
        bus_if.xfer_start  = 1'b1;
        prev_s = bus_if.sclk;
        prev_m = bus_if.mosi;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus_if.xfer_start  = 1'b0;
                bus_if.divider     = 9'h1FF;
                bus_if.xfer_length = 13'd0;
            end
            if (extra_at > 1 && cyc == extra_at) begin
                bus_if.xfer_start  = 1'b1;
                bus_if.xfer_length = 13'd5;
            end
            if (extra_at > 1 && cyc == extra_at + 1) bus_if.xfer_start = 1'b0;
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                timed_out = 1'b0;
                break;
            end
            s = bus_if.sclk;
            m = bus_if.mosi;
            if (s === 1'b1 && prev_s === 1'b0) begin
                rises++;
                mosi_bits.push_back(m);
                if (m !== prev_m) unstable++;
                if (rises > 1) low_runs.push_back(run_l);
                run_h = 1;
            end else if (s === 1'b1) begin
                run_h++;
            end else if (prev_s === 1'b1) begin
                high_runs.push_back(run_h);
                run_l = 1;
            end else begin
                run_l++;
            end
            if (bus_if.xfer_complete === 1'b1) begin
                completes++;
                if (first_complete_cyc == 0) first_complete_cyc = cyc;
            end
            if (miso_mode == 0) bus_if.miso = ~m;
            else                bus_if.miso = miso_pat[7 - (rises % 8)];
            prev_s = s;
            prev_m = m;
            if (completes > 0) begin
                tail++;
                if (tail > 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int         seen;
        total++;
        if (bus_if.sclk !== 1'b0) begin bad++; $display("[TB] FAIL reset_sclk: got %b expected 0", bus_if.sclk); end
        total++;
        if (bus_if.mosi !== 1'b0) begin bad++; $display("[TB] FAIL reset_mosi: got %b expected 0", bus_if.mosi); end
        total++;
        if (bus_if.xfer_complete !== 1'b0) begin bad++; $display("[TB] FAIL reset_complete: got %b expected 0", bus_if.xfer_complete); end
        total++;
        if (bus_if.buf_rd_val !== 8'h00) begin bad++; $display("[TB] FAIL reset_rd_val: got %h expected 00", bus_if.buf_rd_val); end
        @(negedge clk);
        rst_n = 1'b1;

        bus_write(13'd0, 8'hFF);
        exp_q.push_back(8'hFF);
        miso_mode = 0;
        run_xfer(13'd2, 9'd1, 0, 8);
        #1;
        total++;
        if (rises < 1) begin bad++; $display("[TB] FAIL abort_mid_shift: got rises=%0d expected >=1", rises); end
        total++;
        if (bus_if.sclk !== 1'b0) begin bad++; $display("[TB] FAIL abort_sclk: got %b expected 0", bus_if.sclk); end
        total++;
        if (bus_if.mosi !== 1'b0) begin bad++; $display("[TB] FAIL abort_mosi: got %b expected 0", bus_if.mosi); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.xfer_complete === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("[TB] FAIL abort_no_complete: got %0d pulses expected 0", seen); end
        rst_n = 1'b1;

        bus_read(13'd0, v);
        total++;
        if (v !== exp_q.pop_front()) begin bad++; $display("[TB] FAIL abort_buf_untouched: got %h expected ff", v); end

        exp_q.push_back(8'h00);
        run_xfer(13'd1, 9'd0, 0, 0);
        total++;
        if (timed_out) begin bad++; $display("[TB] FAIL post_reset_timeout: got timeout expected complete"); end
        total++;
        if (rises !== 8 || completes !== 1) begin bad++; $display("[TB] FAIL post_reset_xfer: got rises=%0d completes=%0d expected 8 1", rises, completes); end
        bus_read(13'd0, v);
        total++;
        if (v !== exp_q.pop_front()) begin bad++; $display("[TB] FAIL post_reset_buf: got %h expected 00", v); end
    endtask

    task automatic test_bus_port();
        logic [7:0] v;
        bus_write(13'h0010, 8'hA5);
        exp_q.push_back(8'hA5);
        bus_write(13'h1FFF, 8'h3C);
        exp_q.push_back(8'h3C);
        bus_read(13'h0010, v);
        total++;
        if (v !== exp_q.pop_front()) begin bad++; $display("[TB] FAIL bus_rd_0010: got %h expected a5", v); end
        bus_read(13'h1FFF, v);
        total++;
        if (v !== exp_q.pop_front()) begin bad++; $display("[TB] FAIL bus_rd_1fff: got %h expected 3c", v); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        int         bad_runs;
        bus_write(13'd0, 8'h3C);
        bus_write(13'd1, 8'hF0);
        mosi_exp_q.push_back(8'h3C);
        mosi_exp_q.push_back(8'hF0);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h0F);
        miso_mode = 0;
        run_xfer(13'd2, 9'd0, 0, 0);
        total++;
        if (timed_out) begin bad++; $display("[TB] FAIL loop_timeout: got timeout expected complete"); end
        total++;
        if (rises !== 16) begin bad++; $display("[TB] FAIL loop_rises: got %0d expected 16", rises); end
        total++;
        if (completes !== 1) begin bad++; $display("[TB] FAIL loop_completes: got %0d expected 1", completes); end
        bad_runs = 0;
        foreach (high_runs[i]) if (high_runs[i] != 1) bad_runs++;
        foreach (low_runs[i]) if (i != 7 && low_runs[i] != 1) bad_runs++;
        total++;
        if (bad_runs !== 0 || high_runs.size() !== 16) begin bad++; $display("[TB] FAIL loop_period: got %0d bad runs, %0d highs expected 0 16", bad_runs, high_runs.size()); end
        total++;
        if (low_runs.size() < 8 || low_runs[7] < 2) begin bad++; $display("[TB] FAIL loop_byte_gap: got %0d lows expected gap>=2", low_runs.size()); end
        for (int n = 0; n < 2; n++) begin
            v = mosi_exp_q.pop_front();
            total++;
            if (mosi_byte(n) !== v) begin bad++; $display("[TB] FAIL loop_mosi%0d: got %h expected %h", n, mosi_byte(n), v); end
        end
        for (int n = 0; n < 2; n++) begin
            logic [7:0] e;
            bus_read(13'(n), v);
            e = exp_q.pop_front();
            total++;
            if (v !== e) begin bad++; $display("[TB] FAIL loop_buf%0d: got %h expected %h", n, v, e); end
        end
    endtask

    task automatic test_divider();
        logic [7:0] e;
        int         bad_runs;
        bus_write(13'd0, 8'hA6);
        mosi_exp_q.push_back(8'hA6);
        miso_mode = 0;
        run_xfer(13'd1, 9'd3, 0, 0);
        total++;
        if (timed_out) begin bad++; $display("[TB] FAIL div_timeout: got timeout expected complete"); end
        bad_runs = 0;
        foreach (high_runs[i]) if (high_runs[i] != 4) bad_runs++;
        total++;
        if (bad_runs !== 0 || high_runs.size() !== 8) begin bad++; $display("[TB] FAIL div_high: got %0d bad of %0d expected 0 of 8", bad_runs, high_runs.size()); end
        bad_runs = 0;
        foreach (low_runs[i]) if (low_runs[i] != 4) bad_runs++;
        total++;
        if (bad_runs !== 0 || low_runs.size() !== 7) begin bad++; $display("[TB] FAIL div_low: got %0d bad of %0d expected 0 of 7", bad_runs, low_runs.size()); end
        total++;
        if (unstable !== 0) begin bad++; $display("[TB] FAIL div_mosi_stable: got %0d changes expected 0", unstable); end
        e = mosi_exp_q.pop_front();
        total++;
        if (mosi_byte(0) !== e) begin bad++; $display("[TB] FAIL div_msb_first: got %h expected %h", mosi_byte(0), e); end
    endtask

    task automatic test_length_zero();
        run_xfer(13'd0, 9'd0, 0, 0);
        total++;
        if (rises !== 0 || high_runs.size() !== 0) begin bad++; $display("[TB] FAIL len0_sclk: got %0d rises expected 0", rises); end
        total++;
        if (completes !== 1 || first_complete_cyc !== 1) begin bad++; $display("[TB] FAIL len0_complete: got %0d at cyc %0d expected 1 at cyc 1", completes, first_complete_cyc); end
    endtask

    task automatic test_back_to_back();
        miso_mode = 0;
        run_xfer(13'd1, 9'd1, 5, 0);
        total++;
        if (timed_out) begin bad++; $display("[TB] FAIL busy_timeout: got timeout expected complete"); end
        total++;
        if (completes !== 1 || rises !== 8) begin bad++; $display("[TB] FAIL busy_start_ignored: got completes=%0d rises=%0d expected 1 8", completes, rises); end
    endtask

    task automatic test_miso_pattern();
        logic [7:0] v;
        logic [7:0] e;
        bus_write(13'd0, 8'hFF);
        mosi_exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        miso_mode = 1;
        miso_pat  = 8'h5A;
        run_xfer(13'd1, 9'd2, 0, 0);
        total++;
        if (timed_out) begin bad++; $display("[TB] FAIL miso_timeout: got timeout expected complete"); end
        e = mosi_exp_q.pop_front();
        total++;
        if (mosi_byte(0) !== e || rises !== 8) begin bad++; $display("[TB] FAIL miso_mosi: got %h (%0d bits) expected %h", mosi_byte(0), rises, e); end
        bus_read(13'd0, v);
        e = exp_q.pop_front();
        total++;
        if (v !== e) begin bad++; $display("[TB] FAIL miso_buf: got %h expected %h", v, e); end
    endtask

    initial begin
        bus_if.buf_addr    = 13'd0;
        bus_if.buf_wr_val  = 8'h00;
        bus_if.buf_wr_en   = 1'b0;
        bus_if.divider     = 9'd0;
        bus_if.xfer_start  = 1'b0;
        bus_if.xfer_length = 13'd0;
        bus_if.miso        = 1'b0;
        miso_mode = 0;
        miso_pat  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_bus_port();
        test_loopback();
        test_divider();
        test_length_zero();
        test_back_to_back();
        test_miso_pattern();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
